// File: rtl/inst_queue_param.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue_param
// Purpose  : Parametrised instruction queue between IF and ID. Storage FIFO
//            of DEPTH entries behind a registered show-ahead output stage.
//            When storage is empty and the output stage is free, an incoming
//            instruction bypasses storage and loads the output stage directly.
//            The design reports storage occupancy, applies almost-full
//            back-pressure, and keeps a sticky overflow flag.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            rdy               - global ready; low freezes all state
//            clear             - synchronous flush; works even when rdy is low
//            if_valid/if_inst/if_pc - instruction offered by IF
//            almost_full       - registered back-pressure to IF
//            id_ready          - ID accepts the head entry this cycle
//            id_valid/id_inst/id_pc - output stage (head of the queue)
//            count             - storage occupancy, output stage not included
//            overflow_err      - sticky: enqueue attempted while storage full
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue_param #(
  parameter int DEPTH    = 16,
  parameter int INST_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int AF_SLACK = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     clear,
  input  logic                     if_valid,
  input  logic [INST_W-1:0]        if_inst,
  input  logic [ADDR_W-1:0]        if_pc,
  output logic                     almost_full,
  input  logic                     id_ready,
  output logic                     id_valid,
  output logic [INST_W-1:0]        id_inst,
  output logic [ADDR_W-1:0]        id_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] c_depth    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_af_level = CNT_W'(DEPTH - AF_SLACK);

  logic [INST_W-1:0] r_inst_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic              r_id_valid;
  logic [INST_W-1:0] r_id_inst;
  logic [ADDR_W-1:0] r_id_pc;
  logic              r_almost_full;
  logic              r_overflow;

  logic              w_transfer;
  logic              w_free;
  logic              w_empty;
  logic              w_full;
  logic              w_deq;
  logic              w_bypass;
  logic              w_enq;
  logic              w_ovf;
  logic [CNT_W-1:0]  w_count_next;

  // All qualifiers include rdy so that a frozen cycle has no side effects.
  assign w_transfer = r_id_valid & id_ready & rdy;
  assign w_free     = ~r_id_valid | w_transfer;
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_depth);

  // Output stage refill: storage has priority over the bypass path so that
  // ordering stays FIFO; bypass only happens when storage is empty.
  assign w_deq    = rdy & w_free & ~w_empty;
  assign w_bypass = rdy & w_free &  w_empty & if_valid;

  // A dequeue in the same cycle frees a slot even when storage is full.
  assign w_enq = rdy & if_valid & ~w_bypass & (~w_full | w_deq);
  assign w_ovf = rdy & if_valid & ~w_bypass &  w_full & ~w_deq;

  assign w_count_next = r_count + CNT_W'(w_enq) - CNT_W'(w_deq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_id_valid    <= 1'b0;
      r_id_inst     <= '0;
      r_id_pc       <= '0;
      r_almost_full <= 1'b0;
      r_overflow    <= 1'b0;
    end else if (clear) begin
      // Flush drops everything in flight, including this cycle's input;
      // the overflow history is deliberately preserved.
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
      r_id_valid    <= 1'b0;
      r_almost_full <= 1'b0;
    end else if (rdy) begin
      if (w_deq) begin
        r_head <= r_head + 1'b1;
      end
      if (w_enq) begin
        r_tail <= r_tail + 1'b1;
      end
      r_count       <= w_count_next;
      r_almost_full <= (w_count_next >= c_af_level);
      if (w_ovf) begin
        r_overflow <= 1'b1;
      end

      if (w_deq) begin
        r_id_valid <= 1'b1;
        r_id_inst  <= r_inst_mem[r_head];
        r_id_pc    <= r_pc_mem[r_head];
      end else if (w_bypass) begin
        r_id_valid <= 1'b1;
        r_id_inst  <= if_inst;
        r_id_pc    <= if_pc;
      end else if (w_free) begin
        r_id_valid <= 1'b0;
      end
    end
  end

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (!rst && !clear && w_enq) begin
      r_inst_mem[r_tail] <= if_inst;
      r_pc_mem[r_tail]   <= if_pc;
    end
  end

  assign almost_full  = r_almost_full;
  assign id_valid     = r_id_valid;
  assign id_inst      = r_id_inst;
  assign id_pc        = r_id_pc;
  assign count        = r_count;
  assign overflow_err = r_overflow;

endmodule
`default_nettype wire
